tick_rate_ctrl: RTL and testbench

Run/pause and rate-select controller for the board timebase. It owns one mod-k rollover counter and loads its modulus from a four-entry rate table. Rate changes arrive through a valid/ready handshake and take effect only on a rollover boundary, so the derived clock never glitches. Its outputs are a one-cycle tick and a 50 %-duty toggled clock for the LED and clock consumers.

---
 rtl/tick_rate_ctrl_pkg.sv | 32 +++
 rtl/tick_rate_ctrl_if.sv | 24 ++
 rtl/tick_rate_ctrl_tick_counter.sv | 30 +++
 rtl/tick_rate_ctrl.sv | 122 ++++++++++++
 tb/tb_tick_rate_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/tick_rate_ctrl_pkg.sv
// Shared types and default rate table for the board timebase controller.
// The default moduli target a 50 MHz system clock.
package tick_rate_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef logic [1:0] rate_sel_t;

  localparam int unsigned CNT_W      = 28;
  localparam int unsigned K0_DEFAULT = 2_500_000;
  localparam int unsigned K1_DEFAULT = 25_000_000;
  localparam int unsigned K2_DEFAULT = 250_000_000;
  localparam int unsigned K3_DEFAULT = 12_500_000;

  // Once the controller leaves IDLE, only reset brings it back there.
  function automatic state_t next_state(input state_t cur, input logic run);
    state_t nxt;
    nxt = cur;
    case (cur)
      IDLE:    nxt = run ? RUN : IDLE;
      RUN:     nxt = run ? RUN : PAUSE;
      PAUSE:   nxt = run ? RUN : PAUSE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/tick_rate_ctrl_if.sv
// Run/rate-select request bundle and timebase status outputs of tick_rate_ctrl.
interface tick_rate_ctrl_if;
  import tick_rate_pkg::*;

  logic      i_run;
  logic      i_sel_valid;
  rate_sel_t i_sel;
  logic      o_sel_ready;
  rate_sel_t o_sel_active;
  logic      o_tick;
  logic      o_clk;
  logic [1:0] o_state;

  modport master (
    output i_run, i_sel_valid, i_sel,
    input  o_sel_ready, o_sel_active, o_tick, o_clk, o_state
  );

  modport slave (
    input  i_run, i_sel_valid, i_sel,
    output o_sel_ready, o_sel_active, o_tick, o_clk, o_state
  );

endinterface

// File: rtl/tick_rate_ctrl_tick_counter.sv
// Mod-k rollover counter: counts 0..modulus-1 while enabled and flags the wrap edge.
module tick_counter #(
  parameter int unsigned N = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [N-1:0] modulus,
  output logic         wrap
);

  logic [N-1:0] count;
  logic         at_top;

  // Using >= keeps the counter from running away if it is ever above the limit.
  assign at_top = (count >= (modulus - N'(1)));
  assign wrap   = en && at_top;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + N'(1);
    end
  end

endmodule

// File: rtl/tick_rate_ctrl.sv
// Run/pause and rate-select controller for the board timebase; rate changes while
// running are deferred to a rollover boundary so o_clk never glitches.
module tick_rate_ctrl
  import tick_rate_pkg::*;
#(
  parameter int unsigned N  = CNT_W,
  parameter int unsigned K0 = K0_DEFAULT,
  parameter int unsigned K1 = K1_DEFAULT,
  parameter int unsigned K2 = K2_DEFAULT,
  parameter int unsigned K3 = K3_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  tick_rate_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_PAUSE = PAUSE;

  logic [1:0] state_q;
  logic [1:0] state_d;
  rate_sel_t  sel_active_q;
  rate_sel_t  sel_active_d;
  rate_sel_t  pending_sel_q;
  rate_sel_t  pending_sel_d;
  logic       pending_q;
  logic       pending_d;
  logic       sel_ready_q;
  logic       tick_q;
  logic       clk_q;

  logic [N-1:0] k_active;
  logic         in_run;
  logic         cnt_en;
  logic         cnt_clr;
  logic         wrap;
  logic         accept;
  logic         is_new;

  assign in_run = (state_q == ST_RUN);
  assign cnt_en = in_run && bus.i_run;
  assign accept = bus.i_sel_valid && sel_ready_q;
  assign is_new = (bus.i_sel != sel_active_q);
  assign state_d = next_state(state_t'(state_q), bus.i_run);

  always_comb begin
    k_active = N'(K0);
    case (sel_active_q)
      2'd0:    k_active = N'(K0);
      2'd1:    k_active = N'(K1);
      2'd2:    k_active = N'(K2);
      default: k_active = N'(K3);
    endcase
  end

  // While running, a new index waits for the wrap unless it lands on it; when
  // stopped it applies at once and restarts the count from zero.
  always_comb begin
    sel_active_d  = sel_active_q;
    pending_d     = pending_q;
    pending_sel_d = pending_sel_q;
    cnt_clr       = 1'b0;
    if (in_run) begin
      if (wrap && pending_q) begin
        sel_active_d = pending_sel_q;
        pending_d    = 1'b0;
      end else if (accept && is_new) begin
        if (wrap) begin
          sel_active_d = bus.i_sel;
        end else begin
          pending_d     = 1'b1;
          pending_sel_d = bus.i_sel;
        end
      end
    end else if (accept && is_new) begin
      sel_active_d = bus.i_sel;
      cnt_clr      = 1'b1;
    end
  end

  tick_counter #(
    .N (N)
  ) u_counter (
    .clk     (i_clk),
    .rst_n   (i_reset),
    .en      (cnt_en),
    .clr     (cnt_clr),
    .modulus (k_active),
    .wrap    (wrap)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q       <= ST_IDLE;
      sel_active_q  <= '0;
      pending_q     <= 1'b0;
      pending_sel_q <= '0;
      sel_ready_q   <= 1'b1;
      tick_q        <= 1'b0;
      clk_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_active_q  <= sel_active_d;
      pending_q     <= pending_d;
      pending_sel_q <= pending_sel_d;
      sel_ready_q   <= !pending_d;
      tick_q        <= wrap;
      clk_q         <= clk_q ^ wrap;
    end
  end

  assign bus.o_state      = state_q;
  assign bus.o_sel_active = sel_active_q;
  assign bus.o_sel_ready  = sel_ready_q;
  assign bus.o_tick       = tick_q;
  assign bus.o_clk        = clk_q;

  logic unused_pause_code;
  assign unused_pause_code = (ST_PAUSE == 2'd2);

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// Directed bench for tick_rate_ctrl with a small rate table (K = 4, 6, 10, 3);
// expected tick/clock/status values are worked out by hand per scenario.
module tb_tick_rate_ctrl;
  import tick_rate_pkg::*;

  logic clk;
  logic rst_n;
  logic exp_clk;
  int   num_checks;
  int   num_failures;

  tick_rate_ctrl_if bus();

  tick_rate_ctrl #(
    .N  (28),
    .K0 (4),
    .K1 (6),
    .K2 (10),
    .K3 (3)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic run,
                               input logic valid, input rate_sel_t sel);
    rst_n           = rst_v;
    bus.i_run       = run;
    bus.i_sel_valid = valid;
    bus.i_sel       = sel;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkStatus(input string tag, input int st, input int active,
                             input int ready);
    checkOutput({tag, "_state"},  32'(bus.o_state),      32'(st));
    checkOutput({tag, "_active"}, 32'(bus.o_sel_active), 32'(active));
    checkOutput({tag, "_ready"},  32'(bus.o_sel_ready),  32'(ready));
  endtask

  // Runs num edges with i_run held; a tick is due at edge first and every period after.
  task automatic runTicks(input string tag, input int num, input int period,
                          input int first);
    logic exp_tick;
    for (int i = 1; i <= num; i++) begin
      nextCycle();
      exp_tick = (i >= first) && (((i - first) % period) == 0);
      if (exp_tick) exp_clk = ~exp_clk;
      checkOutput({tag, "_tick"}, 32'(bus.o_tick), 32'(exp_tick));
      checkOutput({tag, "_clk"},  32'(bus.o_clk),  32'(exp_clk));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    num_checks   = 0;
    num_failures = 0;
    exp_clk      = 1'b0;

    // Reset held for three edges with run requested: everything stays at reset values.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkStatus("reset", 0, 0, 1);
      checkOutput("reset_tick", 32'(bus.o_tick), 32'd0);
      checkOutput("reset_clk",  32'(bus.o_clk),  32'd0);
    end

    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
    nextCycle();
    checkStatus("run_start", 1, 0, 1);
    checkOutput("run_start_tick", 32'(bus.o_tick), 32'd0);
    runTicks("run", 8, 4, 4);

    // Pause at count 2 for five cycles, then resume: two counting edges to the tick.
    runTicks("pre_pause", 2, 4, 99);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
    nextCycle();
    checkStatus("pause", 2, 0, 1);
    checkOutput("pause_tick", 32'(bus.o_tick), 32'd0);
    checkOutput("pause_clk",  32'(bus.o_clk),  32'(exp_clk));
    runTicks("paused", 4, 4, 99);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
    nextCycle();
    checkStatus("resume", 1, 0, 1);
    checkOutput("resume_tick0", 32'(bus.o_tick), 32'd0);
    runTicks("resume", 2, 4, 2);

    // Switch to sel 1 at count 1: pending until the rollover, then 6-cycle period.
    runTicks("pre_sw", 1, 4, 99);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
    checkStatus("sw_pend", 1, 0, 0);
    runTicks("sw_wait", 1, 4, 99);
    checkStatus("sw_wait", 1, 0, 0);
    runTicks("sw_roll", 1, 4, 1);
    checkStatus("sw_done", 1, 1, 1);
    runTicks("k1", 12, 6, 6);

    // Return to sel 0 through the pending path, accepted at count 0 of K=6.
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
    checkStatus("back_pend", 1, 1, 0);
    runTicks("back", 5, 6, 5);
    checkStatus("back_done", 1, 0, 1);

    // Request sel 3 exactly on the count=3 wrap edge: applied there, ready never drops.
    runTicks("pre_roll", 3, 4, 99);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd3);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
    exp_clk = ~exp_clk;
    checkStatus("roll_acc", 1, 3, 1);
    checkOutput("roll_acc_tick", 32'(bus.o_tick), 32'd1);
    checkOutput("roll_acc_clk",  32'(bus.o_clk),  32'(exp_clk));
    runTicks("k3", 3, 3, 3);
    checkStatus("k3_done", 1, 3, 1);

    // Same-index request at count 1 must not clear the count: tick two edges later.
    runTicks("pre_same", 1, 3, 99);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd3);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
    checkStatus("same", 1, 3, 1);
    checkOutput("same_tick", 32'(bus.o_tick), 32'd0);
    runTicks("same_roll", 1, 3, 1);

    // Switch to sel 2 while paused at count 1: applied next edge and count cleared.
    runTicks("pre_p", 1, 3, 99);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
    nextCycle();
    checkStatus("p", 2, 3, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd2);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
    checkStatus("p_sw", 2, 2, 1);
    checkOutput("p_sw_tick", 32'(bus.o_tick), 32'd0);
    checkOutput("p_sw_clk",  32'(bus.o_clk),  32'(exp_clk));
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
    nextCycle();
    checkStatus("p_res", 1, 2, 1);
    runTicks("k2", 10, 10, 10);

    // Reset while a request is pending: pending dropped, all back to reset values.
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
    checkStatus("rst_pend", 1, 2, 0);
    checkOutput("rst_pend_clk", 32'(bus.o_clk), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    nextCycle();
    exp_clk = 1'b0;
    checkStatus("rst_mid", 0, 0, 1);
    checkOutput("rst_mid_tick", 32'(bus.o_tick), 32'd0);
    checkOutput("rst_mid_clk",  32'(bus.o_clk),  32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
    nextCycle();
    checkStatus("post_rst", 1, 0, 1);
    runTicks("post_rst", 4, 4, 4);
    checkStatus("post_rst_done", 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_failures);
    $finish;
  end

endmodule
